// File: rtl/cfsr_pkg.sv
// Shared definitions for the feedback shift register generator family:
// mode encodings and a lookup of known-primitive Galois tap masks.
package cfsr_pkg;

    localparam logic MODE_LFSR     = 1'b0;
    localparam logic MODE_COMPLETE = 1'b1;

    // Right-shifting Galois tap masks (bit i XORs feedback into bit i; the
    // MSB bit of each mask is the feedback input itself) for widths 3..16.
    // Unsupported widths return zero so a misuse is obvious in simulation.
    function automatic logic [15:0] default_taps(input int width);
        logic [15:0] taps_v;
        case (width)
            3:       taps_v = 16'h0006;
            4:       taps_v = 16'h000C;
            5:       taps_v = 16'h0014;
            6:       taps_v = 16'h0030;
            7:       taps_v = 16'h0060;
            8:       taps_v = 16'h00B8;
            9:       taps_v = 16'h0110;
            10:      taps_v = 16'h0240;
            11:      taps_v = 16'h0500;
            12:      taps_v = 16'h0E08;
            13:      taps_v = 16'h1C80;
            14:      taps_v = 16'h3802;
            15:      taps_v = 16'h6000;
            16:      taps_v = 16'hB400;
            default: taps_v = 16'h0000;
        endcase
        return taps_v;
    endfunction

endpackage

// File: rtl/cfsr_next.sv
// Combinational next-state logic of the Galois feedback shift register.
// In complete mode the feedback bit is inverted whenever the upper bits are
// all zero, which splices the all-zero state into the maximal-length cycle.
module cfsr_next
    import cfsr_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8)
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] next_o
);

    logic             fb_s;
    logic [WIDTH-1:0] next_s;

    // Feedback bit and shifted/tapped next value; TAPS[WIDTH-1] is never read.
    always_comb begin
        fb_s   = state_i[0] ^ ((mode_i == MODE_COMPLETE) && (state_i[WIDTH-1:1] == '0));
        next_s = '0;
        next_s[WIDTH-1] = fb_s;
        for (int i = 0; i < WIDTH - 1; i++) begin
            next_s[i] = state_i[i+1] ^ (TAPS[i] & fb_s);
        end
    end

    assign next_o = next_s;

endmodule

// File: rtl/cfsr_gen.sv
// Parametrised Galois feedback shift register with step enable, seed load,
// LFSR/complete mode select, lock-up recovery, wrap detection and
// measured-period reporting. All state lives here; cfsr_next supplies the
// combinational step.
module cfsr_gen
    import cfsr_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             wrap,
    output logic             lock_err,
    output logic [WIDTH:0]   period_last
);

    localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] CNT_MAX = {(WIDTH+1){1'b1}};

    logic [WIDTH-1:0] state_q,  state_d;
    logic [WIDTH-1:0] start_q,  start_d;
    logic [WIDTH:0]   cnt_q,    cnt_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             wrap_q,   wrap_d;
    logic             lock_q,   lock_d;
    logic [WIDTH-1:0] next_s;

    cfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state_i (state_q),
        .mode_i  (mode),
        .next_o  (next_s)
    );

    // Per-cycle priority: load, then lock-up recovery, then step, else hold.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lock_d   = 1'b0;
        if (load) begin
            state_d = seed_in;
            start_d = seed_in;
            cnt_d   = '0;
        end else if (en && (mode == MODE_LFSR) && (state_q == '0)) begin
            // The zero state is a fixed point of the LFSR; re-seed to escape.
            state_d = SEED;
            start_d = SEED;
            cnt_d   = '0;
            lock_d  = 1'b1;
        end else if (en) begin
            state_d = next_s;
            if (next_s == start_q) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + CNT_ONE;
                cnt_d    = '0;
            end else begin
                // Saturate so an off-cycle start (after a mode change) cannot alias.
                if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, measurement and pulse registers with asynchronous reset to SEED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lock_q   <= lock_d;
        end
    end

    assign state       = state_q;
    assign out_bit     = state_q[0];
    assign wrap        = wrap_q;
    assign lock_err    = lock_q;
    assign period_last = period_q;

endmodule

// File: tb/tb_cfsr_gen.sv
// Self-checking bench for cfsr_gen: a 4-bit instance (taps 4'b0100) and an
// 8-bit instance (default taps) run against an arithmetic reference model,
// plus directed literal checks from hand-computed sequences.
module tb_cfsr_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       en4 = 1'b0, load4 = 1'b0, mode4 = 1'b0;
    logic [3:0] seed4 = 4'h0;
    logic [3:0] state4;
    logic       out4, wrap4, lock4;
    logic [4:0] per4;

    logic       en8 = 1'b0, load8 = 1'b0, mode8 = 1'b0;
    logic [7:0] seed8 = 8'h00;
    logic [7:0] state8;
    logic       out8, wrap8, lock8;
    logic [8:0] per8;

    cfsr_gen #(.WIDTH(4), .TAPS(4'b0100), .SEED(4'hF)) u_dut4 (
        .clk(clk), .rst(rst), .en(en4), .load(load4), .seed_in(seed4), .mode(mode4),
        .state(state4), .out_bit(out4), .wrap(wrap4), .lock_err(lock4), .period_last(per4)
    );

    cfsr_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .load(load8), .seed_in(seed8), .mode(mode8),
        .state(state8), .out_bit(out8), .wrap(wrap8), .lock_err(lock8), .period_last(per8)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model (index 0 = 4-bit, 1 = 8-bit) ----------
    localparam int W_A  [2] = '{4, 8};
    localparam int TP_A [2] = '{4, 'hB8};
    localparam int SD_A [2] = '{'hF, 'hFF};

    int m_st[2], m_start[2], m_cnt[2], m_per[2], m_wrap[2], m_lock[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = SD_A[k]; m_start[k] = SD_A[k]; m_cnt[k] = 0;
            m_per[k] = 0; m_wrap[k] = 0; m_lock[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input bit l, input int s, input bit md);
        int n, msk, cmax, fb, nx;
        n    = W_A[k];
        msk  = (1 << n) - 1;
        cmax = (1 << (n + 1)) - 1;
        if (l) begin
            m_st[k] = s & msk; m_start[k] = s & msk; m_cnt[k] = 0;
            m_wrap[k] = 0; m_lock[k] = 0;
        end else if (e && !md && m_st[k] == 0) begin
            m_st[k] = SD_A[k]; m_start[k] = SD_A[k]; m_cnt[k] = 0;
            m_wrap[k] = 0; m_lock[k] = 1;
        end else if (e) begin
            fb = (m_st[k] & 1) ^ ((md && ((m_st[k] >> 1) == 0)) ? 1 : 0);
            nx = m_st[k] >> 1;
            if (fb != 0) nx = nx ^ ((TP_A[k] & (msk >> 1)) | (1 << (n - 1)));
            if (nx == m_start[k]) begin
                m_wrap[k] = 1;
                m_per[k]  = (m_cnt[k] + 1) & cmax;
                m_cnt[k]  = 0;
            end else begin
                m_wrap[k] = 0;
                m_cnt[k]  = (m_cnt[k] == cmax) ? cmax : m_cnt[k] + 1;
            end
            m_lock[k] = 0;
            m_st[k]   = nx;
        end else begin
            m_wrap[k] = 0; m_lock[k] = 0;
        end
    endtask

    // Model advances on every clock edge, resets asynchronously with the DUT.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, en4, load4, int'(seed4), mode4);
                model_step(1, en8, load8, int'(seed8), mode8);
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("state4",  int'(state4), m_st[0]);
            chk("outbit4", int'(out4),   m_st[0] & 1);
            chk("wrap4",   int'(wrap4),  m_wrap[0]);
            chk("lock4",   int'(lock4),  m_lock[0]);
            chk("period4", int'(per4),   m_per[0]);
            chk("state8",  int'(state8), m_st[1]);
            chk("outbit8", int'(out8),   m_st[1] & 1);
            chk("wrap8",   int'(wrap8),  m_wrap[1]);
            chk("lock8",   int'(lock8),  m_lock[1]);
            chk("period8", int'(per8),   m_per[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] visited;
    int wraps, wrap_at, zero_seen, wrap_at8, wraps8, st_hold, per_hold;

    // ---------------- directed and random stimulus --------------------------
    initial begin
        #1 rst = 1'b1;
        #12 rst = 1'b0;

        chk("rst_state4",  int'(state4), 'hF);
        chk("rst_period4", int'(per4),   0);
        chk("rst_wrap4",   int'(wrap4),  0);
        chk("rst_lock4",   int'(lock4),  0);
        chk("rst_state8",  int'(state8), 'hFF);
        chk("rst_period8", int'(per8),   0);

        // Complete mode: 16-step cycle visiting every state including zero.
        mode4 = 1'b1; en4 = 1'b1; wraps = 0; wrap_at = 0;
        visited = 16'h0000; visited[state4] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            visited[state4] = 1'b1;
            if (wrap4) begin wraps++; wrap_at = i; end
            if (i == 1) begin
                chk("first_step_dut",   int'(state4), 'hB);
                chk("first_step_model", m_st[0],      'hB);
            end
        end
        en4 = 1'b0;
        chk("cmp_wraps",   wraps,         1);
        chk("cmp_wrap_at", wrap_at,       16);
        chk("cmp_visited", int'(visited), 'hFFFF);
        chk("cmp_period",  int'(per4),    16);

        // LFSR mode: 15-step cycle that never shows zero.
        load4 = 1'b1; seed4 = 4'hF; mode4 = 1'b0; tick();
        load4 = 1'b0; en4 = 1'b1; wraps = 0; wrap_at = 0; zero_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (state4 == 4'h0) zero_seen = 1;
            if (wrap4) begin wraps++; wrap_at = i; end
        end
        en4 = 1'b0;
        chk("lfsr_wraps",   wraps,      1);
        chk("lfsr_wrap_at", wrap_at,    15);
        chk("lfsr_period",  int'(per4), 15);
        chk("lfsr_nozero",  zero_seen,  0);

        // Lock-up: zero loaded in LFSR mode recovers to SEED on the next step.
        load4 = 1'b1; seed4 = 4'h0; tick();
        chk("lock_loaded", int'(state4), 0);
        load4 = 1'b0; en4 = 1'b1; tick();
        chk("lock_state", int'(state4), 'hF);
        chk("lock_pulse", int'(lock4),  1);
        chk("lock_nowrap", int'(wrap4), 0);
        en4 = 1'b0; tick();
        chk("lock_clear", int'(lock4), 0);

        // Load beats enable; wrap on the 16th following step in complete mode.
        mode4 = 1'b1; load4 = 1'b1; en4 = 1'b1; seed4 = 4'h5; tick();
        chk("load_prio", int'(state4), 5);
        load4 = 1'b0; wraps = 0; wrap_at = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (wrap4) begin wraps++; if (wrap_at == 0) wrap_at = i; end
        end
        chk("load_wrap_at", wrap_at, 16);
        chk("load_wraps",   wraps,   1);

        // Enable low for ten cycles mid-sequence: everything holds.
        tick(); tick(); tick();
        en4 = 1'b0;
        tick();
        st_hold = int'(state4); per_hold = int'(per4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_state",  int'(state4), st_hold);
            chk("hold_period", int'(per4),   per_hold);
            chk("hold_wrap",   int'(wrap4),  0);
            chk("hold_lock",   int'(lock4),  0);
        end

        // Off-cycle start: counter saturates, then a late wrap reports it.
        mode4 = 1'b1; load4 = 1'b1; seed4 = 4'h0; tick();
        load4 = 1'b0; en4 = 1'b1; tick();
        chk("sat_first", int'(state4), 'hC);
        mode4 = 1'b0; wraps = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wrap4) wraps++;
        end
        chk("sat_no_wrap", wraps, 0);
        mode4 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        en4 = 1'b0;

        // Random traffic on both instances, checked by the model.
        for (int i = 0; i < 400; i++) begin
            en4   = ($urandom_range(0, 3) != 0);
            load4 = ($urandom_range(0, 31) == 0);
            seed4 = 4'($urandom);
            mode4 = ($urandom_range(0, 63) == 0) ? ~mode4 : mode4;
            en8   = ($urandom_range(0, 3) != 0);
            load8 = ($urandom_range(0, 31) == 0);
            seed8 = 8'($urandom);
            mode8 = ($urandom_range(0, 63) == 0) ? ~mode8 : mode8;
            tick();
        end
        load4 = 1'b0; load8 = 1'b0;

        // Asynchronous reset mid-step, then full cycles on both widths.
        en4 = 1'b1; en8 = 1'b1; mode4 = 1'b1; mode8 = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_state4",  int'(state4), 'hF);
        chk("arst_state8",  int'(state8), 'hFF);
        chk("arst_period4", int'(per4),   0);
        chk("arst_period8", int'(per8),   0);
        @(negedge clk);
        #2 rst = 1'b0;
        wrap_at = 0; wrap_at8 = 0; wraps8 = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (wrap4 && wrap_at == 0) wrap_at = i;
            if (wrap8) begin wraps8++; if (wrap_at8 == 0) wrap_at8 = i; end
        end
        en4 = 1'b0; en8 = 1'b0;
        chk("arst_wrap_at4", wrap_at,    16);
        chk("arst_period4b", int'(per4), 16);
        chk("w8_wrap_at",    wrap_at8,   256);
        chk("w8_wraps",      wraps8,     1);
        chk("w8_period",     int'(per8), 256);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
